hazard_fwd_ctrl: RTL and testbench
==================================

Name: hazard_fwd_ctrl

Overview:
- Control-side counterpart of the pipelined MIPS DATAPATH. Consumes the four stage instruction registers IR_D/E/M/W and produces the stall, flush and forwarding-select signals DATAPATH takes as inputs: pc_en, D_en, E_clr and the MF_*_sel lines.
- Sequential content: a shadow busy counter for the multiply/divide unit, and a stall performance counter.

Parameters:
- MULT_CYCLES, 5, busy cycles after mult/multu leaves E.
- DIV_CYCLES, 10, busy cycles after div/divu leaves E.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- IR_D, IR_E, IR_M, IR_W  in  32 each  instruction in each stage; 0 means nop.
- pc_en  out  1  PC write enable; equals ~stall.
- D_en  out  1  D-register enable; equals ~stall.
- E_clr  out  1  E-register clear (bubble insert); equals stall.
- MF_ALUA_E_sel  out  3  E rs operand source.
- MF_ALUB_E_sel  out  3  E rt operand source.
- MF_MemData_E_sel  out  3  E store-data source.
- MF_DMWD_M_sel  out  2  M store-data source.
- md_busy  out  1  shadow MDU busy.
- stall_cnt  out  32  number of cycles with stall=1.

Behaviour:
- Decoded subset: addu, subu, ori, lui, lw, sw, beq, jal, jr, mult, multu, div, divu, mfhi, mflo, mthi, mtlo. Any other encoding is treated as nop (no source, no destination).
- Destination register:
  - rd for addu/subu/mfhi/mflo.
  - rt for ori/lui/lw.
  - 31 for jal.
  - Destination 0 never matches.
- Tuse:
  - 0 for beq rs/rt and jr rs.
  - 1 for ALU/mt*/mult/div sources and for lw/sw base.
  - 2 for sw rt.
- Tnew by instruction class and stage:
  - lw: E=2, M=1, W=0.
  - ALU and mf*: E=1, M=0.
  - jal: 0 everywhere.
- Data stall: for each D source with Tuse t, stall if E has a matching destination with Tnew_E > t, or M has a matching destination with Tnew_M > t.
- No D-stage forwarding exists. Any Tuse=0 source therefore also stalls while a matching producer is in E or M. The W producer is covered by the GRF write-through.
- MDU stall: stall if IR_D is mult/multu/div/divu/mfhi/mflo/mthi/mtlo AND (md_busy OR IR_E is mult/multu/div/divu).
- stall is the OR of the data stall and the MDU stall. It is purely combinational from the IR inputs and md_busy.
- Forward select encoding for the E selects (M matched first, then W; otherwise 0):
  - 0 = register value in E.
  - 1 = M ALU result, when M is ALU/mf* with Tnew_M=0.
  - 2 = M PC+8, when M is jal.
  - 3 = W write data, when W has a matching destination.
- MF_DMWD_M_sel: 1 if W destination matches IR_M rt and IR_M is sw; else 0.
- md counter (4+ bits):
  - At the edge when IR_E is mult/multu, load MULT_CYCLES; when div/divu, load DIV_CYCLES.
  - Else decrement if nonzero.
  - md_busy = (counter != 0).
  - E never stalls, so each start is seen exactly once.
- stall_cnt: increments by 1 at each edge where stall=1. It wraps 0xFFFFFFFF to 0.
- Reset (reset=0 at an edge): md counter = 0, stall_cnt = 0.
  - Reset mid-multiply aborts busy immediately; md_busy reads 0 the next cycle.
  - All combinational outputs follow the IR inputs during reset. DATAPATH clears the IRs, giving pc_en=1, D_en=1, E_clr=0, all selects 0.

Test Plan:
- All IRs 0 after reset → pc_en=1, D_en=1, E_clr=0, all selects 0, stall_cnt=0.
- IR_E=0x8C080000 (lw $8), IR_D=0x01084821 (addu $9,$8,$8):
  - First cycle: stall=1 (E_clr=1, pc_en=0).
  - Next, with lw in M: no stall.
  - Then with lw in W: MF_ALUA_E_sel=3, MF_ALUB_E_sel=3.
  - stall_cnt=1.
- addu $9 in E, beq 0x11290000 in D → stall for 2 cycles (producer in E, then in M). Stall releases when addu reaches W.
- mult 0x01090018 reaches E with mflo 0x00005012 in D:
  - Stall for 1+MULT_CYCLES = 6 cycles.
  - md_busy high 5 cycles.
  - With div, 11 stall cycles.
- IR_M=jal (0x0C000000), IR_E=addu reading $31 (0x03E04821) → MF_ALUA_E_sel=2.
- Mid-division: reset=0 for one edge → md_busy=0 and stall_cnt=0 on the next cycle. A queued mflo in D then proceeds with no stall.

Source files
------------

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding control for the five-stage MIPS pipeline.
// Decodes IR_D/E/M/W and produces stall/flush enables, the E/M forwarding
// selects, a shadow multiply/divide busy counter and a stall-cycle counter.
module hazard_fwd_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_D,
    input  logic [31:0] IR_E,
    input  logic [31:0] IR_M,
    input  logic [31:0] IR_W,
    output logic        pc_en,
    output logic        D_en,
    output logic        E_clr,
    output logic [2:0]  MF_ALUA_E_sel,
    output logic [2:0]  MF_ALUB_E_sel,
    output logic [2:0]  MF_MemData_E_sel,
    output logic [1:0]  MF_DMWD_M_sel,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    localparam int ST_D = 0;
    localparam int ST_E = 1;
    localparam int ST_M = 2;
    localparam int ST_W = 3;

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = ($clog2(MAX_CYC + 1) > 4) ? $clog2(MAX_CYC + 1) : 4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    // Stage index 0..3 = D, E, M, W
    logic [3:0][31:0] ir_all;
    assign ir_all = {IR_W, IR_M, IR_E, IR_D};

    logic [3:0]      is_alu, is_mf, is_mt, is_lw, is_sw, is_beq, is_jal, is_jr;
    logic [3:0]      is_mul, is_div, use_rs, use_rt;
    logic [3:0][4:0] rs_f, rt_f, dst_f;
    logic [3:0][1:0] tnew_f;

    // Per-stage decode; Tnew depends on which stage the instruction sits in
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dec
            localparam logic [1:0] LW_TNEW  = (gi == ST_E) ? 2'd2 : ((gi == ST_M) ? 2'd1 : 2'd0);
            localparam logic [1:0] ALU_TNEW = (gi == ST_E) ? 2'd1 : 2'd0;

            logic [5:0] op;
            logic [5:0] fn;
            logic       r_type;
            logic       is_addsub;
            logic       is_ori;
            logic       is_lui;

            assign op        = ir_all[gi][31:26];
            assign fn        = ir_all[gi][5:0];
            assign r_type    = (op == OP_RTYPE);
            assign is_addsub = r_type && ((fn == FN_ADDU) || (fn == FN_SUBU));
            assign is_ori    = (op == OP_ORI);
            assign is_lui    = (op == OP_LUI);

            assign is_mf[gi]  = r_type && ((fn == FN_MFHI) || (fn == FN_MFLO));
            assign is_mt[gi]  = r_type && ((fn == FN_MTHI) || (fn == FN_MTLO));
            assign is_mul[gi] = r_type && ((fn == FN_MULT) || (fn == FN_MULTU));
            assign is_div[gi] = r_type && ((fn == FN_DIV) || (fn == FN_DIVU));
            assign is_jr[gi]  = r_type && (fn == FN_JR);
            assign is_lw[gi]  = (op == OP_LW);
            assign is_sw[gi]  = (op == OP_SW);
            assign is_beq[gi] = (op == OP_BEQ);
            assign is_jal[gi] = (op == OP_JAL);
            assign is_alu[gi] = is_addsub || is_ori || is_lui;

            assign rs_f[gi] = ir_all[gi][25:21];
            assign rt_f[gi] = ir_all[gi][20:16];

            assign use_rs[gi] = is_addsub || is_ori || is_lw[gi] || is_sw[gi] || is_beq[gi] ||
                                is_jr[gi] || is_mul[gi] || is_div[gi] || is_mt[gi];
            assign use_rt[gi] = is_addsub || is_sw[gi] || is_beq[gi] || is_mul[gi] || is_div[gi];

            assign dst_f[gi] = (is_addsub || is_mf[gi])        ? ir_all[gi][15:11] :
                               (is_ori || is_lui || is_lw[gi]) ? ir_all[gi][20:16] :
                               is_jal[gi]                      ? 5'd31 : 5'd0;

            assign tnew_f[gi] = is_lw[gi]                 ? LW_TNEW  :
                                (is_alu[gi] || is_mf[gi]) ? ALU_TNEW : 2'd0;
        end
    endgenerate

    // Not every decoded field is needed in every stage
    logic unused_ok;
    assign unused_ok = ^{ir_all, is_alu, is_mf, is_mt, is_lw, is_sw, is_beq, is_jal, is_jr,
                         is_mul, is_div, use_rs, use_rt, rs_f, rt_f, dst_f, tnew_f};

    // A D source stalls when E/M holds its producer and the value is not ready in time.
    // Tuse=0 sources have no D-stage forwarding, so any E/M producer stalls them.
    function automatic logic src_stall(input logic       used,
                                       input logic [4:0] src,
                                       input logic [1:0] tuse,
                                       input logic [4:0] dst_e,
                                       input logic [1:0] tnew_e,
                                       input logic [4:0] dst_m,
                                       input logic [1:0] tnew_m);
        logic hit_e;
        logic hit_m;
        hit_e = used && (src != 5'd0) && (src == dst_e);
        hit_m = used && (src != 5'd0) && (src == dst_m);
        return (hit_e && ((tuse == 2'd0) || (tnew_e > tuse))) ||
               (hit_m && ((tuse == 2'd0) || (tnew_m > tuse)));
    endfunction

    // The youngest matching producer wins; an M match that cannot forward yet blocks W
    function automatic logic [2:0] fwd_sel(input logic       used,
                                           input logic [4:0] src,
                                           input logic [4:0] dst_m,
                                           input logic       m_alu,
                                           input logic       m_jal,
                                           input logic [4:0] dst_w);
        logic [2:0] sel;
        sel = 3'd0;
        if (used && (src != 5'd0)) begin
            if (src == dst_m) begin
                if (m_alu)      sel = 3'd1;
                else if (m_jal) sel = 3'd2;
            end else if (src == dst_w) begin
                sel = 3'd3;
            end
        end
        return sel;
    endfunction

    logic [CNT_W-1:0] md_cnt_reg, md_cnt_next;
    logic [31:0]      stall_cnt_reg, stall_cnt_next;
    logic [1:0]       tuse_rs_d, tuse_rt_d;
    logic             data_stall, md_stall, stall;
    logic             d_is_md;

    assign md_busy = (md_cnt_reg != '0);

    // Stall decision: data hazards on D sources plus MDU occupancy
    always_comb begin
        tuse_rs_d = (is_beq[ST_D] || is_jr[ST_D]) ? 2'd0 : 2'd1;
        tuse_rt_d = is_beq[ST_D] ? 2'd0 : (is_sw[ST_D] ? 2'd2 : 2'd1);
        data_stall = src_stall(use_rs[ST_D], rs_f[ST_D], tuse_rs_d,
                               dst_f[ST_E], tnew_f[ST_E], dst_f[ST_M], tnew_f[ST_M]) ||
                     src_stall(use_rt[ST_D], rt_f[ST_D], tuse_rt_d,
                               dst_f[ST_E], tnew_f[ST_E], dst_f[ST_M], tnew_f[ST_M]);
        d_is_md  = is_mul[ST_D] || is_div[ST_D] || is_mf[ST_D] || is_mt[ST_D];
        md_stall = d_is_md && (md_busy || is_mul[ST_E] || is_div[ST_E]);
        stall    = data_stall || md_stall;
    end

    assign pc_en = ~stall;
    assign D_en  = ~stall;
    assign E_clr = stall;

    // Forwarding selects for the E operands and the M store data
    always_comb begin
        MF_ALUA_E_sel    = fwd_sel(use_rs[ST_E], rs_f[ST_E], dst_f[ST_M],
                                   is_alu[ST_M] || is_mf[ST_M], is_jal[ST_M], dst_f[ST_W]);
        MF_ALUB_E_sel    = fwd_sel(use_rt[ST_E], rt_f[ST_E], dst_f[ST_M],
                                   is_alu[ST_M] || is_mf[ST_M], is_jal[ST_M], dst_f[ST_W]);
        MF_MemData_E_sel = fwd_sel(is_sw[ST_E], rt_f[ST_E], dst_f[ST_M],
                                   is_alu[ST_M] || is_mf[ST_M], is_jal[ST_M], dst_f[ST_W]);
        MF_DMWD_M_sel    = (is_sw[ST_M] && (rt_f[ST_M] != 5'd0) && (rt_f[ST_M] == dst_f[ST_W]))
                           ? 2'd1 : 2'd0;
    end

    // MDU shadow counter: load on an E start, otherwise count down to idle
    always_comb begin
        md_cnt_next = md_cnt_reg;
        if (is_div[ST_E])
            md_cnt_next = CNT_W'(DIV_CYCLES);
        else if (is_mul[ST_E])
            md_cnt_next = CNT_W'(MULT_CYCLES);
        else if (md_cnt_reg != '0)
            md_cnt_next = md_cnt_reg - CNT_W'(1);
    end

    // Stall performance counter, wraps naturally at 32 bits
    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (stall)
            stall_cnt_next = stall_cnt_reg + 32'd1;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            md_cnt_reg    <= '0;
            stall_cnt_reg <= '0;
        end else begin
            md_cnt_reg    <= md_cnt_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: a stage-timing model checks every cycle,
// and hand-computed literals pin the key scenarios.
module tb_hazard_fwd_ctrl;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] LW8    = 32'h8C08_0000; // lw  $8, 0($0)
    localparam logic [31:0] ADDU9  = 32'h0108_4821; // addu $9,$8,$8
    localparam logic [31:0] BEQ99  = 32'h1129_0000; // beq $9,$9
    localparam logic [31:0] MULT   = 32'h0109_0018; // mult $8,$9
    localparam logic [31:0] DIV    = 32'h0109_001A; // div  $8,$9
    localparam logic [31:0] MFLO   = 32'h0000_5012; // mflo $10
    localparam logic [31:0] JAL    = 32'h0C00_0000;
    localparam logic [31:0] ADDU31 = 32'h03E0_4821; // addu $9,$31,$0
    localparam logic [31:0] JR31   = 32'h03E0_0008; // jr $31
    localparam logic [31:0] SW_R8  = 32'hAC08_0000; // sw $8, 0($0)
    localparam logic [31:0] SW_R9  = 32'hAD09_0000; // sw $9, 0($8)

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IR_D, IR_E, IR_M, IR_W;
    logic        pc_en, D_en, E_clr, md_busy;
    logic [2:0]  MF_ALUA_E_sel, MF_ALUB_E_sel, MF_MemData_E_sel;
    logic [1:0]  MF_DMWD_M_sel;
    logic [31:0] stall_cnt;

    always #5 clk = ~clk;

    hazard_fwd_ctrl #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .IR_D            (IR_D),
        .IR_E            (IR_E),
        .IR_M            (IR_M),
        .IR_W            (IR_W),
        .pc_en           (pc_en),
        .D_en            (D_en),
        .E_clr           (E_clr),
        .MF_ALUA_E_sel   (MF_ALUA_E_sel),
        .MF_ALUB_E_sel   (MF_ALUB_E_sel),
        .MF_MemData_E_sel(MF_MemData_E_sel),
        .MF_DMWD_M_sel   (MF_DMWD_M_sel),
        .md_busy         (md_busy),
        .stall_cnt       (stall_cnt)
    );

    int         total = 0;
    int         bad   = 0;
    bit         chk_en = 1'b0;
    int         vec_no = 0;
    int         m_md   = 0;
    bit [31:0]  m_cnt  = 32'd0;

    // prod = stage whose end makes the result available (D=0 for jal, E=1 ALU/mf, M=2 lw)
    // tuse = -1 when the field is not a source
    typedef struct packed {
        int dst;
        int prod;
        int rs;
        int rt;
        int tuse_rs;
        int tuse_rt;
        int mdlen;
        bit mdu;
        bit sw;
        bit jal;
    } info_t;

    function automatic info_t decode(input logic [31:0] ir);
        info_t r;
        logic [5:0] op;
        logic [5:0] fn;
        r = '0;
        r.tuse_rs = -1;
        r.tuse_rt = -1;
        r.rs = int'(ir[25:21]);
        r.rt = int'(ir[20:16]);
        op = ir[31:26];
        fn = ir[5:0];
        if (op == 6'h00) begin
            case (fn)
                6'h21, 6'h23: begin r.dst = int'(ir[15:11]); r.prod = 1; r.tuse_rs = 1; r.tuse_rt = 1; end
                6'h10, 6'h12: begin r.dst = int'(ir[15:11]); r.prod = 1; r.mdu = 1'b1; end
                6'h11, 6'h13: begin r.tuse_rs = 1; r.mdu = 1'b1; end
                6'h18, 6'h19: begin r.tuse_rs = 1; r.tuse_rt = 1; r.mdu = 1'b1; r.mdlen = MULT_CYCLES; end
                6'h1A, 6'h1B: begin r.tuse_rs = 1; r.tuse_rt = 1; r.mdu = 1'b1; r.mdlen = DIV_CYCLES; end
                6'h08:        r.tuse_rs = 0;
                default:      ;
            endcase
        end else begin
            case (op)
                6'h0D: begin r.dst = r.rt; r.prod = 1; r.tuse_rs = 1; end
                6'h0F: begin r.dst = r.rt; r.prod = 1; end
                6'h23: begin r.dst = r.rt; r.prod = 2; r.tuse_rs = 1; end
                6'h2B: begin r.tuse_rs = 1; r.tuse_rt = 2; r.sw = 1'b1; end
                6'h04: begin r.tuse_rs = 0; r.tuse_rt = 0; end
                6'h03: begin r.dst = 31; r.prod = 0; r.jal = 1'b1; end
                default: ;
            endcase
        end
        return r;
    endfunction

    // Cycles still needed before the value exists, seen from stage s (E=1, M=2, W=3)
    function automatic int tnew(input info_t p, input int s);
        int t;
        t = p.prod + 1 - s;
        return (t > 0) ? t : 0;
    endfunction

    function automatic int mdlen_of(input logic [31:0] ir);
        info_t r;
        r = decode(ir);
        return r.mdlen;
    endfunction

    function automatic bit model_stall();
        info_t d, p, e;
        int src, tu;
        bit st;
        st = 1'b0;
        d = decode(IR_D);
        e = decode(IR_E);
        for (int k = 0; k < 2; k++) begin
            src = (k == 0) ? d.rs : d.rt;
            tu  = (k == 0) ? d.tuse_rs : d.tuse_rt;
            if (tu >= 0 && src != 0) begin
                for (int s = 1; s <= 2; s++) begin
                    p = decode((s == 1) ? IR_E : IR_M);
                    if (p.dst == src && (tu == 0 || tnew(p, s) > tu)) st = 1'b1;
                end
            end
        end
        if (d.mdu && (m_md > 0 || e.mdlen > 0)) st = 1'b1;
        return st;
    endfunction

    function automatic int model_fwd(input int src, input bit used);
        info_t m, w;
        m = decode(IR_M);
        w = decode(IR_W);
        if (!used || src == 0) return 0;
        if (m.dst == src) return (tnew(m, 2) == 0) ? (m.jal ? 2 : 1) : 0;
        if (w.dst == src) return 3;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Reference state advances at each active edge
    always @(posedge clk) begin
        if (!reset) begin
            m_md  <= 0;
            m_cnt <= 32'd0;
        end else begin
            if (model_stall()) m_cnt <= m_cnt + 32'd1;
            m_md <= (mdlen_of(IR_E) > 0) ? mdlen_of(IR_E) : ((m_md > 0) ? m_md - 1 : 0);
        end
    end

    // Per-cycle comparison of every output against the reference
    always @(negedge clk) begin
        if (chk_en) begin
            info_t e, m, w;
            bit st;
            e  = decode(IR_E);
            m  = decode(IR_M);
            w  = decode(IR_W);
            st = model_stall();
            chk("m_pc_en",   32'(pc_en),   32'(!st));
            chk("m_D_en",    32'(D_en),    32'(!st));
            chk("m_E_clr",   32'(E_clr),   32'(st));
            chk("m_alua",    32'(MF_ALUA_E_sel), 32'(model_fwd(e.rs, e.tuse_rs >= 0)));
            chk("m_alub",    32'(MF_ALUB_E_sel), 32'(model_fwd(e.rt, e.tuse_rt >= 0)));
            chk("m_memdata", 32'(MF_MemData_E_sel), 32'(e.sw ? model_fwd(e.rt, 1'b1) : 0));
            chk("m_dmwd",    32'(MF_DMWD_M_sel),
                32'((m.sw && m.rt != 0 && w.dst == m.rt) ? 1 : 0));
            chk("m_md_busy", 32'(md_busy), 32'(m_md > 0));
            chk("m_stall_cnt", stall_cnt, m_cnt);
        end
    end

    task automatic vec(input logic [31:0] d, input logic [31:0] e,
                       input logic [31:0] m, input logic [31:0] w);
        IR_D = d;
        IR_E = e;
        IR_M = m;
        IR_W = w;
        @(negedge clk);
        vec_no++;
        $display("vec %0d D=%08h E=%08h M=%08h W=%08h rst=%0b clr=%0b A=%0d B=%0d MD=%0d DM=%0d busy=%0b cnt=%0d",
                 vec_no, d, e, m, w, reset, E_clr, MF_ALUA_E_sel, MF_ALUB_E_sel,
                 MF_MemData_E_sel, MF_DMWD_M_sel, md_busy, stall_cnt);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        IR_D = NOP; IR_E = NOP; IR_M = NOP; IR_W = NOP;
        adv();
        adv();
        reset  = 1'b1;
        chk_en = 1'b1;

        // Reset state with cleared pipeline
        vec(NOP, NOP, NOP, NOP);
        chk("rst_pc_en", 32'(pc_en), 32'd1);
        chk("rst_D_en",  32'(D_en),  32'd1);
        chk("rst_E_clr", 32'(E_clr), 32'd0);
        chk("rst_sels",  32'({MF_ALUA_E_sel, MF_ALUB_E_sel, MF_MemData_E_sel, MF_DMWD_M_sel}), 32'd0);
        chk("rst_cnt",   stall_cnt, 32'd0);
        chk("rst_busy",  32'(md_busy), 32'd0);
        adv();

        // Load-use: one stall, then W forwarding
        vec(ADDU9, LW8, NOP, NOP);
        chk("lw_use_clr", 32'(E_clr), 32'd1);
        chk("lw_use_pc",  32'(pc_en), 32'd0);
        adv();
        vec(ADDU9, NOP, LW8, NOP);
        chk("lw_m_clr", 32'(E_clr), 32'd0);
        chk("lw_cnt",   stall_cnt, 32'd1);
        adv();
        vec(NOP, ADDU9, NOP, LW8);
        chk("lw_w_alua", 32'(MF_ALUA_E_sel), 32'd3);
        chk("lw_w_alub", 32'(MF_ALUB_E_sel), 32'd3);
        adv();

        // Branch on a fresh ALU result: two stalls
        vec(BEQ99, ADDU9, NOP, NOP);
        chk("beq_e_clr", 32'(E_clr), 32'd1);
        adv();
        vec(BEQ99, NOP, ADDU9, NOP);
        chk("beq_m_clr", 32'(E_clr), 32'd1);
        adv();
        vec(BEQ99, NOP, NOP, ADDU9);
        chk("beq_w_clr", 32'(E_clr), 32'd0);
        chk("beq_cnt",   stall_cnt, 32'd3);
        adv();

        // mflo behind mult: 1 + MULT_CYCLES stalls
        vec(MFLO, MULT, NOP, NOP);
        chk("mult_start_clr",  32'(E_clr),   32'd1);
        chk("mult_start_busy", 32'(md_busy), 32'd0);
        adv();
        for (int i = 0; i < MULT_CYCLES; i++) begin
            vec(MFLO, NOP, NOP, NOP);
            chk("mult_busy", 32'(md_busy), 32'd1);
            chk("mult_clr",  32'(E_clr),   32'd1);
            adv();
        end
        vec(MFLO, NOP, NOP, NOP);
        chk("mult_done_busy", 32'(md_busy), 32'd0);
        chk("mult_done_clr",  32'(E_clr),   32'd0);
        chk("mult_cnt",       stall_cnt,    32'd9);
        adv();

        // mflo behind div: 1 + DIV_CYCLES stalls
        vec(MFLO, DIV, NOP, NOP);
        adv();
        for (int i = 0; i < DIV_CYCLES; i++) begin
            vec(MFLO, NOP, NOP, NOP);
            adv();
        end
        vec(MFLO, NOP, NOP, NOP);
        chk("div_done_clr", 32'(E_clr), 32'd0);
        chk("div_cnt",      stall_cnt,  32'd20);
        adv();

        // jal in M feeding $31 to E
        vec(NOP, ADDU31, JAL, NOP);
        chk("jal_alua", 32'(MF_ALUA_E_sel), 32'd2);
        chk("jal_alub", 32'(MF_ALUB_E_sel), 32'd0);
        adv();

        // jr has no D forwarding: stalls behind jal in E and in M
        vec(JR31, JAL, NOP, NOP);
        chk("jr_e_clr", 32'(E_clr), 32'd1);
        adv();
        vec(JR31, NOP, JAL, NOP);
        chk("jr_m_clr", 32'(E_clr), 32'd1);
        adv();
        vec(JR31, NOP, NOP, JAL);
        chk("jr_w_clr", 32'(E_clr), 32'd0);
        adv();

        // sw data has Tuse=2: lw in E does not stall it
        vec(SW_R8, LW8, NOP, NOP);
        chk("sw_tuse2_clr", 32'(E_clr), 32'd0);
        adv();

        // Store data forwarding in E and in M
        vec(NOP, SW_R9, ADDU9, NOP);
        chk("sw_memdata", 32'(MF_MemData_E_sel), 32'd1);
        chk("sw_alua",    32'(MF_ALUA_E_sel),    32'd0);
        adv();
        vec(NOP, NOP, SW_R9, ADDU9);
        chk("sw_dmwd", 32'(MF_DMWD_M_sel), 32'd1);
        adv();

        // Reset in the middle of a division
        vec(MFLO, DIV, NOP, NOP);
        adv();
        vec(MFLO, NOP, NOP, NOP);
        adv();
        vec(MFLO, NOP, NOP, NOP);
        adv();
        reset = 1'b0;
        vec(MFLO, NOP, NOP, NOP);
        adv();
        reset = 1'b1;
        vec(MFLO, NOP, NOP, NOP);
        chk("abort_busy", 32'(md_busy), 32'd0);
        chk("abort_cnt",  stall_cnt,    32'd0);
        chk("abort_clr",  32'(E_clr),   32'd0);
        adv();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
